// File: rtl/miner_pkg.sv
// Shared widths and FSM state encoding for the nonce scheduler.
package miner_pkg;

    localparam int NONCE_W = 32;
    localparam int BLOCK_W = 512;
    localparam int TAIL_W  = 96;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } miner_state_e;

endpackage

// File: rtl/miner_nonce_ctr.sv
// Nonce counter with inclusive-end final detection.
// The end check uses modular distance, so ranges that wrap past 2^32 work.
module miner_nonce_ctr
    import miner_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NONCE_W-1:0] start_nonce,
    input  logic [NONCE_W-1:0] end_nonce,
    input  logic               advance,
    output logic [NONCE_W-1:0] nonce,
    output logic               is_final
);

    localparam logic [NONCE_W-1:0] STEP_W = NONCE_W'(STEP);

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] end_q, end_d;

    // Next nonce / end: load wins over advance; otherwise hold.
    always_comb begin
        nonce_d = nonce_q;
        end_d   = end_q;
        if (load) begin
            nonce_d = start_nonce;
            end_d   = end_nonce;
        end else if (advance) begin
            nonce_d = nonce_q + STEP_W;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q <= '0;
            end_q   <= '0;
        end else begin
            nonce_q <= nonce_d;
            end_q   <= end_d;
        end
    end

    assign nonce    = nonce_q;
    assign is_final = ((end_q - nonce_q) < STEP_W);

endmodule

// File: rtl/miner_nonce_sched.sv
// Nonce scheduler: accepts a mining job, fixes the header words and issues
// nonces downstream over a valid/ready link until the range is exhausted.
// Optional macro MINER_NONCE_STRIDE_EN: step = NONCE_STRIDE instead of 1.
// Handshake: a nonce transfers on any rising edge where nonce_valid and
// nonce_ready are both high; nonce/block1_fixed/tail_fixed hold otherwise.
module miner_nonce_sched
    import miner_pkg::*;
#(
    parameter int unsigned NONCE_STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [BLOCK_W-1:0] job_block1,
    input  logic [TAIL_W-1:0]  job_tail,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_end,
    input  logic               abort,
    output logic [BLOCK_W-1:0] block1_fixed,
    output logic [TAIL_W-1:0]  tail_fixed,
    output logic [NONCE_W-1:0] nonce,
    output logic               nonce_valid,
    input  logic               nonce_ready,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

`ifdef MINER_NONCE_STRIDE_EN
    localparam int unsigned STEP = NONCE_STRIDE;
`else
    // Stride parameter is accepted but the step is fixed at one.
    localparam int unsigned STEP = (NONCE_STRIDE > 0) ? 1 : 1;
`endif

    miner_state_e       state_q, state_d;
    logic [BLOCK_W-1:0] block1_q, block1_d;
    logic [TAIL_W-1:0]  tail_q, tail_d;
    logic               load, advance, is_final;

    // Next-state logic; abort beats a coinciding transfer so no further nonce starts.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (nonce_ready) begin
                    if (is_final) state_d = ST_DONE;
                    else          advance = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Header copies only change when a job is accepted.
    always_comb begin
        block1_d = load ? job_block1 : block1_q;
        tail_d   = load ? job_tail   : tail_q;
    end

    // State and header registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            block1_q <= '0;
            tail_q   <= '0;
        end else begin
            state_q  <= state_d;
            block1_q <= block1_d;
            tail_q   <= tail_d;
        end
    end

    miner_nonce_ctr #(
        .STEP(STEP)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .start_nonce(job_nonce_start),
        .end_nonce  (job_nonce_end),
        .advance    (advance),
        .nonce      (nonce),
        .is_final   (is_final)
    );

    assign job_ready    = (state_q == ST_IDLE);
    assign nonce_valid  = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign block1_fixed = block1_q;
    assign tail_fixed   = tail_q;
    assign state_dbg    = state_q;

endmodule
